// File: rtl/serializer_pkg.sv
// Shared types and constants for the bit serializer.
// Holds the FSM state encoding and the frame-length legality rule.
package serializer_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    function automatic logic len_ok(
        input int unsigned len,
        input int unsigned width
    );
        return (len >= 1) && (len <= width);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle of the serializer.
// master = upstream producer and stream observer, slave = serializer.
interface bit_serializer_if #(
    parameter int WIDTH = serializer_pkg::DEF_WIDTH
);
    import serializer_pkg::*;

    localparam int LW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] data_in;
    logic [LW-1:0]    len_in;
    logic             valid_in;
    logic             ready_out;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_done;
    logic             len_err;

    modport master (
        output data_in, len_in, valid_in,
        input  ready_out, ser_out, ser_valid, frame_done, len_err
    );

    modport slave (
        input  data_in, len_in, valid_in,
        output ready_out, ser_out, ser_valid, frame_done, len_err
    );

endinterface

// File: rtl/serializer_fifo2.sv
// Two-entry FIFO holding {len, data} words ahead of the shifter.
// Push into a full FIFO and pop from an empty one are ignored.
module serializer_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr;
    logic          r_rd;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_data  = r_mem[r_rd];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wr <= ~r_wr;
            if (w_pop)  r_rd <= ~r_rd;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/bit_serializer.sv
// Buffers words in a 2-deep FIFO and shifts them out MSB-first,
// with GAP idle cycles between frames and illegal lengths dropped.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter int   GAP        = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic              clk,
    input logic              reset,
    bit_serializer_if.slave  bus
);

    localparam int LW = $clog2(WIDTH) + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int DW = LW + WIDTH;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [LW-1:0]    r_cnt;
    logic [LW-1:0]    w_cnt_nxt;
    logic [GW-1:0]    r_gap;
    logic [GW-1:0]    w_gap_nxt;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_done;
    logic             r_err;

    logic [DW-1:0]    w_fifo_d;
    logic [DW-1:0]    w_fifo_q;
    logic             w_full;
    logic             w_empty;
    logic [1:0]       w_count;
    logic             w_ready;
    logic             w_push;
    logic             w_take;
    logic             w_pop;
    logic             w_drop;
    logic [WIDTH-1:0] w_hd_data;
    logic [LW-1:0]    w_hd_len;
    logic             w_hd_ok;
    logic [WIDTH-1:0] w_hd_aligned;

    assign w_ready  = (w_count != 2'd2);
    assign w_push   = bus.valid_in && !w_full;
    assign w_fifo_d = {bus.len_in, bus.data_in};

    serializer_fifo2 #(.DW(DW)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (w_fifo_d),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Left-align the frame so the next bit is always the register MSB.
    assign {w_hd_len, w_hd_data} = w_fifo_q;
    assign w_hd_ok      = len_ok(32'(w_hd_len), WIDTH);
    assign w_hd_aligned = w_hd_data << (LW'(WIDTH) - w_hd_len);

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_take      = 1'b0;
        unique case (r_state)
            ST_IDLE: w_take = 1'b1;
            ST_SHIFT: begin
                if (r_cnt == LW'(1)) begin
                    if (GAP > 0) begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = GW'(GAP - 1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_take      = 1'b1;
                    end
                end else begin
                    w_shift_nxt = r_shift << 1;
                    w_cnt_nxt   = r_cnt - LW'(1);
                end
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_take      = 1'b1;
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // The last gap cycle doubles as the idle decision point.
        w_pop  = w_take && !w_empty;
        w_drop = w_pop && !w_hd_ok;
        if (w_pop && w_hd_ok) begin
            w_state_nxt = ST_SHIFT;
            w_shift_nxt = w_hd_aligned;
            w_cnt_nxt   = w_hd_len;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_ser_out   <= IDLE_LEVEL;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gap       <= w_gap_nxt;
            r_ser_valid <= (w_state_nxt == ST_SHIFT);
            r_ser_out   <= (w_state_nxt == ST_SHIFT) ?
                           w_shift_nxt[WIDTH-1] : IDLE_LEVEL;
            r_done      <= (w_state_nxt == ST_SHIFT) &&
                           (w_cnt_nxt == LW'(1));
            r_err       <= w_drop;
        end
    end

    assign bus.ready_out  = w_ready;
    assign bus.ser_out    = r_ser_out;
    assign bus.ser_valid  = r_ser_valid;
    assign bus.frame_done = r_done;
    assign bus.len_err    = r_err;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed frames plus random words
// checked against a queue of accepted words.
module tb_bit_serializer;
    import serializer_pkg::*;

    localparam int   W  = 8;
    localparam logic IL = 1'b0;

    typedef struct {
        logic [7:0] d;
        int         len;
    } word_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) bus  ();
    bit_serializer_if #(.WIDTH(W)) bus0 ();

    bit_serializer #(.WIDTH(W), .GAP(1), .IDLE_LEVEL(IL)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    bit_serializer #(.WIDTH(W), .GAP(0), .IDLE_LEVEL(IL)) dut0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    word_t       exp_q[$];
    int          exp_err = 0;
    int          obs_err = 0;
    int          n_valid = 0;
    int          cur_len = 0;
    logic [15:0] cur_val = '0;
    int          last_done = -1;
    bit          prev_valid = 1'b0;
    bit          gap_chk = 1'b0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        if (bus.len_err) obs_err++;
        if (bus.ser_valid) begin
            n_valid++;
            if (gap_chk && !prev_valid && last_done >= 0)
                check("gap_len", cyc - last_done - 1, 1);
            cur_val = {cur_val[14:0], bus.ser_out};
            cur_len++;
            if (bus.frame_done) begin
                last_done = cyc;
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 1, 0);
                end else begin
                    word_t       w;
                    logic [15:0] m;
                    w = exp_q.pop_front();
                    m = 16'(w.d) & ((16'd1 << w.len) - 16'd1);
                    check("frame_len", cur_len, w.len);
                    check("frame_bits", cur_val, m);
                end
                cur_val = '0;
                cur_len = 0;
            end
        end else begin
            check("idle_level", bus.ser_out, IL);
            check("done_wo_valid", bus.frame_done, 0);
        end
        prev_valid = bus.ser_valid;
    endtask

    task automatic step();
        if (bus.valid_in && bus.ready_out) begin
            if (bus.len_in >= 1 && bus.len_in <= W) begin
                word_t w;
                w.d   = bus.data_in;
                w.len = int'(bus.len_in);
                exp_q.push_back(w);
            end else begin
                exp_err++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic offer(logic [7:0] d, logic [3:0] l);
        bus.data_in  = d;
        bus.len_in   = l;
        bus.valid_in = 1'b1;
    endtask

    task automatic expect_frame(string tag, logic [7:0] d, int len);
        for (int i = 0; i < len; i++) begin
            check({tag, "_valid"}, bus.ser_valid, 1);
            check({tag, "_bit"}, bus.ser_out, d[len-1-i]);
            check({tag, "_done"}, bus.frame_done, (i == len - 1));
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          e0;
        int          v0;
        bit          acc;
        logic [7:0]  pat;

        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.len_in    = '0;
        bus0.valid_in = 1'b0;
        bus0.data_in  = '0;
        bus0.len_in   = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", bus.ready_out, 1);
        check("rst_valid", bus.ser_valid, 0);
        check("rst_out", bus.ser_out, IL);
        check("rst_done", bus.frame_done, 0);
        check("rst_err", bus.len_err, 0);
        rst_n = 1'b1;

        // Full-width frame, one-edge latency, one gap cycle
        offer(8'hB5, 4'd8);
        check("a_ready", bus.ready_out, 1);
        step();
        bus.valid_in = 1'b0;
        check("a_lat", bus.ser_valid, 0);
        step();
        expect_frame("a", 8'hB5, 8);
        check("a_gap", bus.ser_valid, 0);
        step();

        // Short frame
        offer(8'h05, 4'd3);
        step();
        bus.valid_in = 1'b0;
        step();
        expect_frame("b", 8'h05, 3);
        check("b_after", bus.ser_valid, 0);
        repeat (2) step();

        // Back-pressure with four words
        gap_chk   = 1'b1;
        last_done = -1;
        offer(8'h3C, 4'd8);
        step();
        offer(8'hA7, 4'd8);
        check("c_rdy1", bus.ready_out, 1);
        step();
        offer(8'h1E, 4'd8);
        check("c_rdy2", bus.ready_out, 1);
        step();
        offer(8'hC3, 4'd8);
        check("c_full", bus.ready_out, 0);
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = bus.ready_out;
            step();
        end
        bus.valid_in = 1'b0;
        check("c_w4_acc", acc, 1);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
        check("c_drain", exp_q.size(), 0);
        gap_chk = 1'b0;
        repeat (3) step();

        // Illegal lengths
        e0 = obs_err;
        v0 = n_valid;
        offer(8'h55, 4'd0);
        step();
        bus.valid_in = 1'b0;
        repeat (2) step();
        offer(8'hAA, 4'd9);
        step();
        bus.valid_in = 1'b0;
        repeat (4) step();
        check("d_err_cnt", obs_err - e0, 2);
        check("d_no_valid", n_valid - v0, 0);

        // Reset mid-frame
        v0 = n_valid;
        offer(8'hFF, 4'd8);
        step();
        bus.valid_in = 1'b0;
        for (int k = 0; k < 10 && (n_valid - v0) < 3; k++) step();
        check("e_three_bits", n_valid - v0, 3);
        #2 rst_n = 1'b0;
        #1;
        check("e_rst_out", bus.ser_out, IL);
        check("e_rst_valid", bus.ser_valid, 0);
        check("e_rst_done", bus.frame_done, 0);
        check("e_rst_ready", bus.ready_out, 1);
        exp_q.delete();
        cur_val    = '0;
        cur_len    = 0;
        prev_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        v0 = n_valid;
        repeat (10) step();
        check("e_silent", n_valid - v0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        offer(8'h96, 4'd8);
        check("e_first_rdy", bus.ready_out, 1);
        step();
        bus.valid_in = 1'b0;
        check("e_lat", bus.ser_valid, 0);
        step();
        expect_frame("e", 8'h96, 8);
        repeat (2) step();

        // GAP=0 instance: back-to-back frames
        pat = 8'hA5;
        bus0.data_in  = 8'h0A;
        bus0.len_in   = 4'd4;
        bus0.valid_in = 1'b1;
        check("f_rdy1", bus0.ready_out, 1);
        step();
        bus0.data_in = 8'h05;
        check("f_rdy2", bus0.ready_out, 1);
        step();
        bus0.valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("f_valid", bus0.ser_valid, 1);
            check("f_bit", bus0.ser_out, pat[7-i]);
            check("f_done", bus0.frame_done, (i == 3 || i == 7));
            step();
        end
        check("f_end", bus0.ser_valid, 0);

        // Random words, held while not accepted
        for (int k = 0; k < 400; k++) begin
            acc = bus.valid_in && bus.ready_out;
            if (acc || !bus.valid_in) begin
                int r;
                r = $urandom_range(0, 9);
                bus.valid_in = ($urandom_range(0, 9) < 6);
                bus.data_in  = 8'($urandom);
                if (r < 8)       bus.len_in = 4'(r + 1);
                else if (r == 8) bus.len_in = 4'd0;
                else             bus.len_in = 4'(9 + $urandom_range(0, 6));
            end
            step();
        end
        bus.valid_in = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
        repeat (4) step();
        check("g_drain", exp_q.size(), 0);
        check("g_partial", cur_len, 0);
        check("g_err_total", obs_err, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
